// File: rtl/turbo_rsc_if.sv
// Stream bundle for the RSC constituent encoder: block length, input bit stream,
// output systematic/parity beats and the length-error pulse.
interface turbo_rsc_if #(
  parameter int CW = 13
);
  logic [CW-1:0] blk_len;
  logic          in_valid;
  logic          in_ready;
  logic          in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic          out_sys;
  logic          out_par;
  logic          out_tail;
  logic          out_last;
  logic          err_len;

  modport master (
    output blk_len, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sys, out_par, out_tail, out_last, err_len
  );

  modport slave (
    input  blk_len, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sys, out_par, out_tail, out_last, err_len
  );
endinterface

// File: rtl/turbo_rsc_encoder.sv
// Streaming recursive systematic convolutional encoder with per-block length,
// single-register output stage with backpressure and M trellis-termination tail beats.
module turbo_rsc_encoder #(
  parameter int         M     = 3,
  parameter logic [M:0] G_FB  = 4'b1101,
  parameter logic [M:0] G_FF  = 4'b1011,
  parameter int         K_MAX = 6144,
  parameter int         CW    = $clog2(K_MAX + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  turbo_rsc_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam int         TW     = $clog2(M + 1);

  // Tap vector bit j multiplies s[j], i.e. polynomial coefficient of D^(j+1).
  function automatic logic tap_parity(input logic [M-1:0] taps, input logic [M-1:0] st);
    return ^(taps & st);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [M-1:0]  s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sys_q, out_sys_d;
  logic          out_par_q, out_par_d;
  logic          out_tail_q, out_tail_d;
  logic          out_last_q, out_last_d;
  logic          err_len_q, err_len_d;

  logic          fb, ff, a_data, p_data;
  logic          advance, in_ready_c, accept, first, hit_max, bad_len, last_tail;
  logic [CW-1:0] len_eff, cnt_next;

  always_comb begin
    fb         = tap_parity(G_FB[M:1], s_q);
    ff         = tap_parity(G_FF[M:1], s_q);
    a_data     = bus.in_data ^ fb;
    p_data     = (G_FF[0] & a_data) ^ ff;
    advance    = !out_valid_q || bus.out_ready;
    in_ready_c = (state_q != S_TAIL) && advance;
    accept     = bus.in_valid && in_ready_c;
    first      = (state_q == S_IDLE);
    len_eff    = first ? bus.blk_len : len_q;
    cnt_next   = first ? CW'(1) : (cnt_q + CW'(1));
    hit_max    = (cnt_next == CW'(K_MAX));
    bad_len    = (bus.blk_len == '0) || (bus.blk_len > CW'(K_MAX));
    last_tail  = (tcnt_q == TW'(M - 1));

    state_d     = state_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tcnt_d      = tcnt_q;
    err_len_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_sys_d   = out_sys_q;
    out_par_d   = out_par_q;
    out_tail_d  = out_tail_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          s_d         = {s_q[M-2:0], a_data};
          cnt_d       = cnt_next;
          len_d       = len_eff;
          // Hitting K_MAX without in_last is an error and forces termination.
          err_len_d   = (first && bad_len) || (bus.in_last ? (cnt_next != len_eff) : hit_max);
          out_valid_d = 1'b1;
          out_sys_d   = bus.in_data;
          out_par_d   = p_data;
          out_tail_d  = 1'b0;
          out_last_d  = 1'b0;
          if (bus.in_last || hit_max) begin
            state_d = S_TAIL;
            tcnt_d  = '0;
          end else begin
            state_d = S_DATA;
          end
        end else if (advance) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      S_TAIL: begin
        if (advance) begin
          // Input forced to the feedback term, so a = 0 and zeros shift in.
          s_d         = {s_q[M-2:0], 1'b0};
          out_valid_d = 1'b1;
          out_sys_d   = fb;
          out_par_d   = ff;
          out_tail_d  = 1'b1;
          out_last_d  = last_tail;
          if (last_tail) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tcnt_d  = '0;
          end else begin
            tcnt_d  = tcnt_q + TW'(1);
          end
        end else begin
          state_d = S_TAIL;
        end
      end
      default: begin
        state_d     = S_IDLE;
        s_d         = '0;
        cnt_d       = '0;
        tcnt_d      = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      tcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_sys_q   <= 1'b0;
      out_par_q   <= 1'b0;
      out_tail_q  <= 1'b0;
      out_last_q  <= 1'b0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tcnt_q      <= tcnt_d;
      out_valid_q <= out_valid_d;
      out_sys_q   <= out_sys_d;
      out_par_q   <= out_par_d;
      out_tail_q  <= out_tail_d;
      out_last_q  <= out_last_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sys   = out_sys_q;
  assign bus.out_par   = out_par_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_last  = out_last_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// Self-checking bench for turbo_rsc_encoder: directed tables plus randomized
// blocks scored against a polynomial-recurrence reference model.
module tb_turbo_rsc_encoder;
  localparam int         M     = 3;
  localparam logic [M:0] G_FB  = 4'b1101;
  localparam logic [M:0] G_FF  = 4'b1011;
  localparam int         K_MAX = 6144;
  localparam int         CW    = $clog2(K_MAX + 1);

  typedef struct packed {
    logic sys;
    logic par;
    logic tail;
    logic last;
  } beat_t;

  typedef struct {
    logic  u;
    beat_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  turbo_rsc_if #(.CW(CW)) bus();

  turbo_rsc_encoder #(.M(M), .G_FB(G_FB), .G_FF(G_FF), .K_MAX(K_MAX), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [M:0]    gfb = G_FB;
  logic [M:0]    gff = G_FF;
  int            tests = 0;
  int            fails = 0;
  int            vpct = 100;
  int            rpct = 100;
  int            force_rdy = -1;
  bit            blk_bits[$];
  int            blk_idx = 0;
  bit            drv_active = 1'b0;
  logic [CW-1:0] cur_len = '0;
  beat_t         exp_q[$];
  beat_t         rx_log[$];
  beat_t         prev_beat;
  bit            prev_stall = 1'b0;
  bit            prev_acc = 1'b0;
  bit            err_exp = 1'b0;
  int            err_seen = 0;
  int            cyc = 0;
  int            last_acc_cyc = 0;
  int            gap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a[n] = u[n] ^ sum G_FB[i] a[n-i]; p[n] = sum G_FF[i] a[n-i]; tail drives a[n]=0.
  function automatic void model_block(input bit bits[$]);
    int    k;
    bit    a_h[$];
    bit    fbs, ffs, u, a;
    beat_t b;
    k = bits.size();
    for (int n = 0; n < k + M; n++) begin
      fbs = 1'b0;
      ffs = 1'b0;
      for (int i = 1; i <= M; i++) begin
        if (n - i >= 0) begin
          fbs ^= gfb[i] & a_h[n-i];
          ffs ^= gff[i] & a_h[n-i];
        end
      end
      if (n < k) begin
        u = bits[n];
        a = u ^ fbs;
      end else begin
        u = fbs;
        a = 1'b0;
      end
      b.sys  = u;
      b.par  = (gff[0] & a) ^ ffs;
      b.tail = (n >= k);
      b.last = (n == k + M - 1);
      exp_q.push_back(b);
      a_h.push_back(a);
    end
  endfunction

  task automatic cycle();
    beat_t cur;
    @(negedge clk);
    if (drv_active && blk_idx < blk_bits.size()) begin
      bus.in_valid = ($urandom_range(0, 99) < vpct);
      bus.in_data  = blk_bits[blk_idx];
      bus.in_last  = (blk_idx == blk_bits.size() - 1);
      bus.blk_len  = cur_len;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
    bus.out_ready = (force_rdy >= 0) ? (force_rdy != 0) : ($urandom_range(0, 99) < rpct);
    #1;
    cyc++;
    cur = {bus.out_sys, bus.out_par, bus.out_tail, bus.out_last};
    check("err_len", 32'(bus.err_len), 32'(err_exp));
    if (bus.err_len) err_seen++;
    if (prev_acc) check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    if (prev_stall) check("stall_hold", {27'd0, bus.out_valid, cur}, {27'd0, 1'b1, prev_beat});
    if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    err_exp  = 1'b0;
    prev_acc = bus.in_valid && bus.in_ready;
    if (prev_acc) begin
      if (blk_idx == 0 && (cur_len == '0 || int'(cur_len) > K_MAX)) err_exp = 1'b1;
      if (bus.in_last && blk_bits.size() != int'(cur_len)) err_exp = 1'b1;
      if (blk_idx == 0) gap = cyc - last_acc_cyc;
      last_acc_cyc = cyc;
      blk_idx++;
    end
    if (bus.out_valid && bus.out_ready) begin
      rx_log.push_back(cur);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %b with nothing expected (cycle %0d)", cur, cyc);
      end else begin
        check("beat{sys,par,tail,last}", 32'(cur), 32'(exp_q.pop_front()));
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_beat  = cur;
  endtask

  // mode: 0 all-zero, 1 first bits from impulse table, 2 random; abort_at/stall_at 0 = unused
  task automatic run_block(input int k, input int len, input int mode, input bit pre[$],
                           input int vp, input int rp, input int abort_at, input int stall_at);
    int  target, saved;
    bit  stalled;
    blk_bits.delete();
    for (int i = 0; i < k; i++) begin
      if (mode == 2)            blk_bits.push_back(1'($urandom_range(0, 1)));
      else if (i < pre.size())  blk_bits.push_back(pre[i]);
      else                      blk_bits.push_back(1'b0);
    end
    model_block(blk_bits);
    cur_len    = CW'(len);
    blk_idx    = 0;
    vpct       = vp;
    rpct       = rp;
    drv_active = 1'b1;
    stalled    = 1'b0;
    target     = (abort_at > 0) ? abort_at : k;
    for (int c = 0; c < k * 40 + 200 && blk_idx < target; c++) begin
      if (stall_at > 0 && blk_idx == stall_at && !stalled) begin
        saved     = blk_idx;
        force_rdy = 0;
        repeat (5) cycle();
        force_rdy = -1;
        stalled   = 1'b1;
        check("stall_no_accept", 32'(blk_idx), 32'(saved));
      end
      cycle();
    end
    check("block_inputs_accepted", 32'(blk_idx), 32'(target));
    drv_active = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 20000 && exp_q.size() > 0; c++) cycle();
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {26'd0, bus.out_valid, bus.out_sys, bus.out_par, bus.out_tail,
                            bus.out_last, bus.err_len}, 32'd0);
    exp_q.delete();
    err_exp    = 1'b0;
    prev_stall = 1'b0;
    prev_acc   = 1'b0;
    drv_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[5];
    bit    imp[$];
    bit    none[$];
    int    e0, n_last, n_tail, par_or;
    tbl[0] = '{u: 1'b1, exp: 4'b1100};
    tbl[1] = '{u: 1'b0, exp: 4'b0100};
    tbl[2] = '{u: 1'b0, exp: 4'b0100};
    tbl[3] = '{u: 1'b0, exp: 4'b0100};
    tbl[4] = '{u: 1'b0, exp: 4'b0000};

    rst_n        = 1'b0;
    bus.blk_len  = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = 1'b0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    // All-zero block
    rx_log.delete();
    e0 = err_seen;
    run_block(40, 40, 0, none, 100, 100, 0, 0);
    drain();
    n_last = 0;
    par_or = 0;
    foreach (rx_log[i]) begin
      n_last += int'(rx_log[i].last);
      par_or |= int'(rx_log[i].par);
    end
    check("zero_blk_beats", 32'(rx_log.size()), 32'd43);
    check("zero_blk_parity_or", 32'(par_or), 32'd0);
    check("zero_blk_last_count", 32'(n_last), 32'd1);
    check("zero_blk_last_pos", 32'(rx_log[42]), 32'b0011);
    check("zero_blk_err", 32'(err_seen - e0), 32'd0);

    // Impulse block straight into an all-zero block
    rx_log.delete();
    foreach (tbl[i]) imp.push_back(tbl[i].u);
    run_block(40, 40, 1, imp, 100, 100, 0, 0);
    run_block(40, 40, 0, none, 100, 100, 0, 0);
    drain();
    check("block_gap", 32'(gap), 32'(M + 1));
    for (int i = 0; i < 5; i++) check($sformatf("impulse_beat%0d", i + 1), 32'(rx_log[i]), 32'(tbl[i].exp));
    par_or = 0;
    for (int i = 43; i < rx_log.size(); i++) par_or |= int'(rx_log[i].par);
    check("post_impulse_zero_parity", 32'(par_or), 32'd0);

    // Backpressure mid-block
    run_block(40, 40, 2, none, 100, 100, 0, 15);
    drain();

    // Length mismatch: 39 bits declared as 40
    rx_log.delete();
    e0 = err_seen;
    run_block(39, 40, 2, none, 100, 100, 0, 0);
    drain();
    n_tail = 0;
    foreach (rx_log[i]) n_tail += int'(rx_log[i].tail);
    check("mismatch_err_pulses", 32'(err_seen - e0), 32'd1);
    check("mismatch_tail_beats", 32'(n_tail), 32'(M));
    check("mismatch_beats", 32'(rx_log.size()), 32'(39 + M));

    // Reset in the middle of a block, then a fresh random block
    run_block(40, 40, 2, none, 100, 100, 20, 0);
    do_reset();
    run_block(40, 40, 2, none, 100, 100, 0, 0);
    drain();

    // Random back-to-back blocks with random valid/ready
    e0 = err_seen;
    for (int b = 0; b < 5; b++) begin
      int k;
      k = $urandom_range(40, 1200);
      run_block(k, k, 2, none, $urandom_range(60, 100), $urandom_range(60, 100), 0, 0);
    end
    run_block(K_MAX, K_MAX, 2, none, 90, 90, 0, 0);
    drain();
    check("random_err_pulses", 32'(err_seen - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
